// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_ctrl_pkg                                                               |
// | Shared types and defaults for the instruction/data memory access control.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package mem_ctrl_pkg;

    localparam int          c_addr_w_def = 32;
    localparam logic [3:0]  c_be_all     = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DREAD  = 2'd2,
        ST_DWRITE = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_ctrl                                                            |
// | Arbitrates fetch and data requests onto a single Avalon-MM master port.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = c_addr_w_def
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [3:0]        data_be,
    input  logic [31:0]       data_wdata,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [3:0]        byteenable,
    output logic [31:0]       writedata,
    input  logic              waitrequest,
    input  logic [31:0]       readdata,
    output logic              fetch_done,
    output logic              data_done,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              err
);

    state_e              r_state;

    logic                r_fpend;
    logic [ADDR_W-1:0]   r_faddr;
    logic                r_dpend;
    logic                r_dwe;
    logic [ADDR_W-1:0]   r_daddr;
    logic [3:0]          r_dbe;
    logic [31:0]         r_dwdata;

    logic [ADDR_W-1:0]   r_address;
    logic                r_read;
    logic                r_write;
    logic [3:0]          r_be;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic                r_fdone;
    logic                r_ddone;
    logic                r_err;

    logic                w_idle;
    logic                w_start_d;
    logic                w_start_f;
    logic                w_d_we;
    logic [ADDR_W-1:0]   w_d_addr;
    logic [3:0]          w_d_be;
    logic [31:0]         w_d_wdata;
    logic [ADDR_W-1:0]   w_f_addr;
    logic                w_dreq_direct;
    logic                w_freq_direct;

    // A pending slot always wins over a fresh pulse; a pulse arriving in IDLE
    // with its slot empty is issued straight from the input pins.
    assign w_idle        = (r_state == ST_IDLE);
    assign w_start_d     = w_idle & (r_dpend | data_req);
    assign w_start_f     = w_idle & ~w_start_d & (r_fpend | fetch_req);
    assign w_dreq_direct = w_start_d & ~r_dpend;
    assign w_freq_direct = w_start_f & ~r_fpend;

    assign w_d_we    = r_dpend ? r_dwe    : data_we;
    assign w_d_addr  = r_dpend ? r_daddr  : data_addr;
    assign w_d_be    = r_dpend ? r_dbe    : data_be;
    assign w_d_wdata = r_dpend ? r_dwdata : data_wdata;
    assign w_f_addr  = r_fpend ? r_faddr  : fetch_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dpend  <= 1'b0;
            r_dwe    <= 1'b0;
            r_daddr  <= '0;
            r_dbe    <= 4'h0;
            r_dwdata <= 32'h0;
        end else begin
            if (w_start_d && r_dpend) begin
                r_dpend <= 1'b0;
            end
            if (data_req && !r_dpend && !w_dreq_direct) begin
                r_dpend  <= 1'b1;
                r_dwe    <= data_we;
                r_daddr  <= data_addr;
                r_dbe    <= data_be;
                r_dwdata <= data_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fpend <= 1'b0;
            r_faddr <= '0;
        end else begin
            if (w_start_f && r_fpend) begin
                r_fpend <= 1'b0;
            end
            if (fetch_req && !r_fpend && !w_freq_direct) begin
                r_fpend <= 1'b1;
                r_faddr <= fetch_addr;
            end
        end
    end

    // A pulse hitting an occupied slot is dropped, even when that slot is
    // being issued on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if ((data_req && r_dpend) || (fetch_req && r_fpend)) begin
            r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_address <= '0;
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_be      <= 4'h0;
            r_wdata   <= 32'h0;
            r_rdata   <= 32'h0;
            r_fdone   <= 1'b0;
            r_ddone   <= 1'b0;
        end else begin
            r_fdone <= 1'b0;
            r_ddone <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_d) begin
                        r_state   <= w_d_we ? ST_DWRITE : ST_DREAD;
                        r_read    <= ~w_d_we;
                        r_write   <= w_d_we;
                        r_address <= w_d_addr;
                        r_be      <= w_d_be;
                        r_wdata   <= w_d_wdata;
                    end else if (w_start_f) begin
                        r_state   <= ST_FETCH;
                        r_read    <= 1'b1;
                        r_address <= w_f_addr;
                        r_be      <= c_be_all;
                    end
                end
                ST_FETCH, ST_DREAD, ST_DWRITE: begin
                    if (!waitrequest) begin
                        r_state <= ST_IDLE;
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        if (r_state != ST_DWRITE) begin
                            r_rdata <= readdata;
                        end
                        r_fdone <= (r_state == ST_FETCH);
                        r_ddone <= (r_state != ST_FETCH);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                end
            endcase
        end
    end

    assign address    = r_address;
    assign read       = r_read;
    assign write      = r_write;
    assign byteenable = r_be;
    assign writedata  = r_wdata;
    assign rdata      = r_rdata;
    assign fetch_done = r_fdone;
    assign data_done  = r_ddone;
    assign busy       = (r_state != ST_IDLE);
    assign err        = r_err;

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, 32, bus address width.
REQ-002 SHALL have port clk  in  1  single system clock, rising-edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port fetch_req  in  1  one-cycle pulse requesting an instruction read.
REQ-005 SHALL have port fetch_addr  in  ADDR_W  fetch address, sampled with fetch_req.
REQ-006 SHALL have port data_req  in  1  one-cycle pulse requesting a data access.
REQ-007 SHALL have ports data_we (in, 1), data_addr (in, ADDR_W), data_be (in, 4) and data_wdata (in, 32): write flag, address, byte enables and store data, all sampled with data_req.
REQ-008 SHALL have ports address (out, ADDR_W), read (out, 1), write (out, 1), byteenable (out, 4) and writedata (out, 32) forming the Avalon-MM master.
REQ-009 SHALL have ports waitrequest (in, 1) and readdata (in, 32) from memory.
REQ-010 SHALL have ports fetch_done (out, 1), data_done (out, 1) and rdata (out, 32): completion pulses and captured read data.
REQ-011 SHALL have ports busy (out, 1), meaning state not IDLE, and err (out, 1), a sticky overflow flag.

Function
REQ-012 SHALL implement states IDLE, FETCH, DREAD, DWRITE.
REQ-013 SHALL hold one pending slot per requester; a req pulse sets its slot and latches its inputs, and a slot already set is not overwritten.
REQ-014 SHALL in IDLE start the data slot before the fetch slot, and SHALL accept a req pulse arriving in IDLE at that same edge without an extra cycle.
REQ-015 SHALL on start clear the slot, load address/byteenable/writedata from it (fetch: byteenable 4'hF) and move to FETCH, DREAD or DWRITE.
REQ-016 SHALL drive read=1 only in FETCH/DREAD and write=1 only in DWRITE, with all bus outputs registered and stable while waitrequest=1.
REQ-017 SHALL complete an access on the edge where read|write=1 and waitrequest=0: capture readdata into rdata for reads, return to IDLE, and pulse fetch_done or data_done for exactly the following cycle.
REQ-018 SHALL give a minimum latency of 2 cycles from req edge to done with waitrequest=0, plus one cycle per waitrequest=1 cycle.
REQ-019 SHALL leave rdata unchanged by writes and hold it until the next read completes.
REQ-020 SHALL set err when a req pulse arrives while its slot is set, dropping that request; err clears only on reset.
REQ-021 SHALL, on simultaneous data_req and fetch_req in IDLE, run data first and fetch immediately after data completes.
REQ-022 SHALL ignore readdata when read=0.

Reset
REQ-023 SHALL on reset assert asynchronously force state IDLE; read, write, fetch_done, data_done, busy and err to 0; clear both slots; and set address, byteenable, writedata and rdata to 0.
REQ-024 SHALL abandon an in-flight access on reset with no done pulse, and SHALL accept requests from the first edge after deassertion.

Structure
REQ-025 SHALL take the state enum and default ADDR_W from shared package mem_ctrl_pkg.
REQ-026 SHALL be a single module with no sub-modules.

Verification
REQ-027 Fetch 0x0000_0040, waitrequest=0, readdata 0x2402_0005 -> read high 1 cycle, fetch_done at req+2, rdata=0x2402_0005.
REQ-028 Data write to 0x100, be 4'b0011, wdata 0xDEAD_BEEF, waitrequest high 3 cycles -> write held 4 cycles with stable outputs, data_done at req+5, rdata unchanged.
REQ-029 data_req (read 0x200) and fetch_req (0x44) in the same IDLE cycle -> DREAD then FETCH back-to-back, data_done before fetch_done, 4 cycles total.
REQ-030 Second fetch_req while a fetch is pending -> err=1, only the first fetch is issued, and err persists until reset.
REQ-031 reset asserted mid-DREAD with waitrequest=1 -> read=0 immediately, no done pulse, rdata=0, and a fresh fetch afterwards completes normally.
